// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared sizing helpers for the synchronous FIFO family
package sync_fifo_pkg;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int idx_width(input int depth);
        return ($clog2(depth) > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// sync_fifo_fwft_if: push/pop, status and threshold bundle of the FWFT FIFO
interface sync_fifo_fwft_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    import sync_fifo_pkg::*;
    localparam int CNT_W = cnt_width(DEPTH);

    logic             flush_i;
    logic             push_i;
    logic [WIDTH-1:0] data_i;
    logic             full_o;
    logic             pop_i;
    logic [WIDTH-1:0] data_o;
    logic             empty_o;
    logic [CNT_W-1:0] level_o;
    logic [CNT_W-1:0] afull_thresh_i;
    logic [CNT_W-1:0] aempty_thresh_i;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic             overflow_o;
    logic             underflow_o;
    logic             err_clr_i;

    modport slave (
        input  flush_i, push_i, data_i, pop_i, afull_thresh_i, aempty_thresh_i, err_clr_i,
        output full_o, data_o, empty_o, level_o, almost_full_o, almost_empty_o,
               overflow_o, underflow_o
    );

    modport master (
        output flush_i, push_i, data_i, pop_i, afull_thresh_i, aempty_thresh_i, err_clr_i,
        input  full_o, data_o, empty_o, level_o, almost_full_o, almost_empty_o,
               overflow_o, underflow_o
    );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: indices, level, flags and accept logic of the FWFT FIFO (no data path)
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int OUT_REG = 1,
    localparam int SD      = (OUT_REG != 0) ? DEPTH - 1 : DEPTH,
    localparam int CNT_W   = cnt_width(DEPTH),
    localparam int IW      = idx_width(SD)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             err_clr_i,
    input  logic [CNT_W-1:0] afull_thresh_i,
    input  logic [CNT_W-1:0] aempty_thresh_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] level_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic             wr_en_o,
    output logic [IW-1:0]    wr_idx_o,
    output logic [IW-1:0]    rd_idx_o,
    output logic             rd_adv_o,
    output logic             bypass_o
);
    logic             push_acc, pop_acc;
    logic [CNT_W-1:0] level_q, level_d;
    logic [IW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;

    function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
        return (i == IW'(SD - 1)) ? '0 : i + IW'(1);
    endfunction

    assign push_acc = ~flush_i & push_i & (~full_q | pop_i);
    assign pop_acc  = ~flush_i & pop_i & ~empty_q;
    // The output register takes data_i directly when storage has nothing older to offer
    assign bypass_o = (OUT_REG != 0) & push_acc & (empty_q | (pop_acc & (level_q == CNT_W'(1))));
    // With an output register, level 1 lives entirely in that register, so storage is untouched
    assign rd_adv_o = pop_acc & ((OUT_REG == 0) | (level_q > CNT_W'(1)));
    assign wr_en_o  = push_acc & ~bypass_o;

    // Next-state for level, indices, status flops and sticky error flags
    always_comb begin
        level_d = flush_i ? '0 :
                  (push_acc & ~pop_acc) ? level_q + CNT_W'(1) :
                  (pop_acc & ~push_acc) ? level_q - CNT_W'(1) : level_q;
        wr_d    = flush_i ? '0 : wr_en_o ? inc(wr_q) : wr_q;
        rd_d    = flush_i ? '0 : rd_adv_o ? inc(rd_q) : rd_q;
        full_d  = level_d == CNT_W'(DEPTH);
        empty_d = level_d == '0;
        ovf_d   = (~flush_i & push_i & full_q & ~pop_i) | (ovf_q & ~err_clr_i);
        udf_d   = (~flush_i & pop_i & empty_q) | (udf_q & ~err_clr_i);
    end

    // Control state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign level_o        = level_q;
    assign almost_full_o  = level_q >= afull_thresh_i;
    assign almost_empty_o = level_q <= aempty_thresh_i;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;
    assign wr_idx_o       = wr_q;
    assign rd_idx_o       = rd_q;
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO, any depth, optional output register
module sync_fifo_fwft
    import sync_fifo_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 8,
    parameter  int OUT_REG = 1,
    localparam int SD      = (OUT_REG != 0) ? DEPTH - 1 : DEPTH,
    localparam int IW      = idx_width(SD)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    sync_fifo_fwft_if.slave bus
);
    logic             wr_en, rd_adv, bypass;
    logic [IW-1:0]    wr_idx, rd_idx;
    logic [WIDTH-1:0] mem_q [SD];

    sync_fifo_ctrl #(.DEPTH(DEPTH), .OUT_REG(OUT_REG)) u_ctrl (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (bus.flush_i),
        .push_i         (bus.push_i),
        .pop_i          (bus.pop_i),
        .err_clr_i      (bus.err_clr_i),
        .afull_thresh_i (bus.afull_thresh_i),
        .aempty_thresh_i(bus.aempty_thresh_i),
        .full_o         (bus.full_o),
        .empty_o        (bus.empty_o),
        .level_o        (bus.level_o),
        .almost_full_o  (bus.almost_full_o),
        .almost_empty_o (bus.almost_empty_o),
        .overflow_o     (bus.overflow_o),
        .underflow_o    (bus.underflow_o),
        .wr_en_o        (wr_en),
        .wr_idx_o       (wr_idx),
        .rd_idx_o       (rd_idx),
        .rd_adv_o       (rd_adv),
        .bypass_o       (bypass)
    );

    // Storage array write port; contents are never reset
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_idx] <= bus.data_i;
    end

    if (OUT_REG != 0) begin : g_reg
        logic [WIDTH-1:0] out_q, out_d;
        // Head register refills from data_i on bypass, otherwise from the oldest stored entry
        always_comb begin
            out_d = bypass ? bus.data_i : rd_adv ? mem_q[rd_idx] : out_q;
        end
        // Head register flop
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) out_q <= '0;
            else         out_q <= out_d;
        end
        assign bus.data_o = out_q;
    end else begin : g_comb
        assign bus.data_o = mem_q[rd_idx];
    end
endmodule
